bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 14, binary input width; legal range 4..14.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  conversion request, sampled in IDLE only.
REQ-005 SHALL have port bin  input  BIN_W  unsigned binary value to convert.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when a new result is loaded.
REQ-008 SHALL have ports ones, tens, hundreds, thousands  output  4 each  registered BCD digits for the seven-segment display stage.
REQ-009 SHALL have port ovf  output  1  overflow flag, present only when BIN2BCD_OVF_EN is defined.

Function
REQ-010 SHALL implement sequential shift-add-3 (double dabble), one bit per clock, MSB first.
REQ-011 SHALL use FSM states IDLE, SHIFT and LOAD; transitions: IDLE->SHIFT on start, SHIFT->LOAD after BIN_W shifts, LOAD->IDLE unconditionally.
REQ-012 SHALL, on start in IDLE, latch bin into a shift register, clear the 16-bit BCD scratch and the bit counter, and assert busy from the next cycle.
REQ-013 SHALL, each SHIFT cycle, add 3 to every scratch digit >= 5 and then shift {scratch, shift register} left by one.
REQ-014 SHALL, in LOAD, copy the scratch to the digit outputs and pulse done for exactly one cycle.
REQ-015 SHALL have fixed latency: start sampled at edge N -> done high during cycle N+BIN_W+1, busy deasserted in that same cycle.
REQ-016 SHALL keep busy high for BIN_W cycles only, and low in IDLE and LOAD.
REQ-017 SHALL ignore start while busy or in LOAD, with no queuing and no effect on the running conversion.
REQ-018 SHALL accept start in the cycle after done, giving back-to-back throughput of one result per BIN_W+2 cycles.
REQ-019 SHALL hold the digit outputs stable between LOAD cycles so the display never shows partial results.
REQ-020 SHALL drop the carry out of the thousands digit, so that values above 9999 yield the value mod 10000 when overflow handling is compiled out.

Reset
REQ-021 SHALL on rst force state IDLE, busy=0, done=0, all digits=0, ovf=0 (if present), and clear the counter and scratch.
REQ-022 SHALL abort any conversion in progress when rst is asserted; the digits remain 0 after release and no done pulse is issued.

Configuration
REQ-023 SHALL compile in overflow handling only when macro BIN2BCD_OVF_EN is defined.
REQ-024 SHALL, with BIN2BCD_OVF_EN defined, compare the latched bin > 9999; if true, LOAD SHALL drive all digits to 9 and set ovf=1, and otherwise clear ovf. ovf updates only in LOAD.
REQ-025 SHALL, without BIN2BCD_OVF_EN, have no ovf port and follow REQ-020.

Structure
REQ-026 SHALL take the following from shared package bin2bcd_pkg: the 4-bit bcd_digit_t typedef, the state enum type, and the constant BCD_MAX=9999.
REQ-027 SHALL instantiate one combinational sub-module bcd_add3 (digit in -> digit+3 if >= 5, else unchanged) per digit, four instances in total.

Verification
REQ-028 SHALL verify: bin=0, start pulse -> done at cycle 15, digits 0/0/0/0.
REQ-029 SHALL verify: bin=1234 -> thousands=1, hundreds=2, tens=3, ones=4; busy high for exactly 14 cycles.
REQ-030 SHALL verify: bin=9999 -> 9/9/9/9, ovf=0; then bin=12345 -> with macro 9/9/9/9 and ovf=1, without macro 2/3/4/5.
REQ-031 SHALL verify: start for 1234, start with bin=42 at cycle 5 -> ignored, result 1234, single done pulse.
REQ-032 SHALL verify: convert 777, then rst asserted at cycle 7 of the next conversion -> digits 0, no done, and the next start with bin=56 -> 0/0/5/6.
REQ-033 SHALL verify: start reasserted the cycle after done with bin=8 -> second done exactly 16 cycles after the first, digits 0/0/0/8.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int unsigned BCD_MAX = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, MSB first.
// Optional overflow saturation/flag is compiled in with macro BIN2BCD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; digit outputs hold the last result
// SHIFT | one correct-and-shift step per cycle, BIN_W steps in total
// LOAD  | result is on the digit outputs, done is high for this cycle
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output bcd_digit_t       ones,
  output bcd_digit_t       tens,
  output bcd_digit_t       hundreds,
  output bcd_digit_t       thousands
`ifdef BIN2BCD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [15:0]      scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      bcd_q;
  logic             last_shift;

  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i(scr_q[4*g +: 4]),
      .digit_o(scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    last_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Carry out of the thousands digit falls off the top here.
        {scr_d, sr_d} = {scr_adj, sr_q} << 1;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          last_shift = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_pend_q;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        ovf_pend_q <= (32'(bin) > BCD_MAX);
      end
      // Result registers are written on the edge entering LOAD so they are
      // valid for the whole cycle in which done is high.
      if (last_shift) begin
        ovf_q <= ovf_pend_q;
        bcd_q <= ovf_pend_q ? 16'h9999 : scr_d;
      end
    end
  end

  assign ovf = ovf_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
    end else if (last_shift) begin
      bcd_q <= scr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == LOAD);
  assign thousands = bcd_q[15:12];
  assign hundreds  = bcd_q[11:8];
  assign tens      = bcd_q[7:4];
  assign ones      = bcd_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table plus start-ignore, reset-abort
// and back-to-back sequences. Works with or without BIN2BCD_OVF_EN.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy, done;
  logic [3:0]       ones, tens, hundreds, thousands;
`ifdef BIN2BCD_OVF_EN
  logic             ovf;
`endif

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
`ifdef BIN2BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [BIN_W-1:0] b;
    logic [15:0]      exp_bcd;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  function automatic logic cur_ovf();
`ifdef BIN2BCD_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Start is high during cycle 0 (sampled at the edge ending it); k counts
  // cycles after that. Optional second start pulse in cycle inj_k.
  task automatic conv(input logic [BIN_W-1:0] b, input int inj_k,
                      input logic [BIN_W-1:0] inj_b, input int window,
                      output int lat, output int lat2, output int busy_n,
                      output int done_n, output logic [15:0] dig,
                      output logic [15:0] dig2, output logic ovf_s);
    @(negedge clk);
    bin = b; start = 1'b1;
    lat = -1; lat2 = -1; busy_n = 0; done_n = 0;
    dig = '0; dig2 = '0; ovf_s = 1'b0;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) bin = inj_b;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; dig = digits(); ovf_s = cur_ovf();
        end else if (lat2 < 0) begin
          lat2 = k; dig2 = digits();
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, lat2, busy_n, done_n, dn;
    logic [15:0] dig, dig2;
    logic ovf_s;

    vecs.push_back('{14'd0,     16'h0000, 1'b0});
    vecs.push_back('{14'd1234,  16'h1234, 1'b0});
    vecs.push_back('{14'd9999,  16'h9999, 1'b0});
`ifdef BIN2BCD_OVF_EN
    vecs.push_back('{14'd12345, 16'h9999, 1'b1});
    vecs.push_back('{14'd16383, 16'h9999, 1'b1});
`else
    vecs.push_back('{14'd12345, 16'h2345, 1'b0});
    vecs.push_back('{14'd16383, 16'h6383, 1'b0});
`endif
    vecs.push_back('{14'd5,     16'h0005, 1'b0});
    vecs.push_back('{14'd10,    16'h0010, 1'b0});
    vecs.push_back('{14'd8191,  16'h8191, 1'b0});
    vecs.push_back('{14'd7,     16'h0007, 1'b0});

    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset digits", 32'(digits()), 32'h0);
    chk("reset ovf", 32'(cur_ovf()), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      conv(vecs[i].b, 0, '0, 20, lat, lat2, busy_n, done_n, dig, dig2, ovf_s);
      chk($sformatf("v%0d digits", i), 32'(dig), 32'(vecs[i].exp_bcd));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(BIN_W + 1));
      chk($sformatf("v%0d busy cycles", i), 32'(busy_n), 32'(BIN_W));
      chk($sformatf("v%0d done pulses", i), 32'(done_n), 32'd1);
      chk($sformatf("v%0d ovf", i), 32'(ovf_s), 32'(vecs[i].exp_ovf));
    end

    // Start with a different value mid-conversion must be ignored.
    conv(14'd1234, 5, 14'd42, 20, lat, lat2, busy_n, done_n, dig, dig2, ovf_s);
    chk("ignore digits", 32'(dig), 32'h1234);
    chk("ignore done pulses", 32'(done_n), 32'd1);
    chk("ignore latency", 32'(lat), 32'(BIN_W + 1));
    chk("ignore hold digits", 32'(digits()), 32'h1234);

    // Reset in the middle of a conversion.
    conv(14'd777, 0, '0, 20, lat, lat2, busy_n, done_n, dig, dig2, ovf_s);
    chk("777 digits", 32'(dig), 32'h0777);
    @(negedge clk);
    bin = 14'd300; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (k == 6) chk("pre-reset busy", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort digits", 32'(digits()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort no done", 32'(dn), 32'd0);
    chk("abort digits after", 32'(digits()), 32'h0);
    conv(14'd56, 0, '0, 20, lat, lat2, busy_n, done_n, dig, dig2, ovf_s);
    chk("post-reset digits", 32'(dig), 32'h0056);

    // Back-to-back: restart in the cycle right after done.
    conv(14'd4321, BIN_W + 2, 14'd8, 35, lat, lat2, busy_n, done_n, dig, dig2, ovf_s);
    chk("b2b first digits", 32'(dig), 32'h4321);
    chk("b2b second digits", 32'(dig2), 32'h0008);
    chk("b2b spacing", 32'(lat2 - lat), 32'(BIN_W + 2));
    chk("b2b done pulses", 32'(done_n), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
